// File: rtl/seq_div_nbit.sv
// ============================================================================
//  Module   : seq_div_nbit
//  Purpose  : Multi-cycle restoring divider, signed/unsigned, {quotient,remainder}
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_div_nbit #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   M,
    input  logic [WIDTH-1:0]   Q,
    output logic [2*WIDTH-1:0] z,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] c_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_ZERO = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     qr_q, qr_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sq_q, sq_d;
    logic                 sm_q, sm_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic [2*WIDTH-1:0]   z_q, z_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;
    logic                 ovf_q, ovf_d;

    logic                 w_sgn;
    logic                 w_sq;
    logic                 w_sm;
    logic [WIDTH-1:0]     w_q_mag;
    logic [WIDTH-1:0]     w_m_mag;
    logic [WIDTH:0]       w_a_sh;
    logic [WIDTH:0]       w_trial;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;

    assign w_sgn   = is_signed & SIGNED_EN;
    assign w_sq    = Q[WIDTH-1] & w_sgn;
    assign w_sm    = M[WIDTH-1] & w_sgn;
    assign w_q_mag = w_sq ? -Q : Q;
    assign w_m_mag = w_sm ? -M : M;

    // Accumulator is one bit wider than the operands so a shifted partial
    // remainder never loses its MSB when the divisor itself has bit W-1 set.
    assign w_a_sh  = {a_q[WIDTH-1:0], qr_q[WIDTH-1]};
    assign w_trial = w_a_sh - {1'b0, m_q};

    assign w_quot  = (sq_q ^ sm_q) ? -qr_q : qr_q;
    assign w_rem   = sq_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            qr_q       <= '0;
            m_q        <= '0;
            cnt_q      <= '0;
            sq_q       <= 1'b0;
            sm_q       <= 1'b0;
            ovf_pend_q <= 1'b0;
            z_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            qr_q       <= qr_d;
            m_q        <= m_d;
            cnt_q      <= cnt_d;
            sq_q       <= sq_d;
            sm_q       <= sm_d;
            ovf_pend_q <= ovf_pend_d;
            z_q        <= z_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        qr_d       = qr_q;
        m_d        = m_q;
        cnt_d      = cnt_q;
        sq_d       = sq_q;
        sm_d       = sm_q;
        ovf_pend_d = ovf_pend_q;
        z_d        = z_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sq_d       = w_sq;
                    sm_d       = w_sm;
                    a_d        = '0;
                    m_d        = w_m_mag;
                    cnt_d      = CW'(WIDTH);
                    ovf_pend_d = w_sgn && (Q == c_MIN_NEG) && (M == c_ALL_ONES);
                    dbz_d      = 1'b0;
                    ovf_d      = 1'b0;
                    busy_d     = 1'b1;
                    if (M == '0) begin
                        // Keep the raw dividend: a zero divide returns it untouched.
                        qr_d    = Q;
                        state_d = S_ZERO;
                    end else begin
                        qr_d    = w_q_mag;
                        state_d = S_ITER;
                    end
                end
            end

            S_ITER: begin
                if (w_trial[WIDTH] == 1'b0) begin
                    a_d  = w_trial;
                    qr_d = {qr_q[WIDTH-2:0], 1'b1};
                end else begin
                    a_d  = w_a_sh;
                    qr_d = {qr_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (ovf_pend_q) begin
                    z_d = {c_MIN_NEG, {WIDTH{1'b0}}};
                end else begin
                    z_d = {w_quot, w_rem};
                end
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            S_ZERO: begin
                z_d     = {c_ALL_ONES, qr_q};
                dbz_d   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign z           = z_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_div_nbit.sv
// ============================================================================
//  Module   : tb_seq_div_nbit
//  Purpose  : Directed self-checking bench for seq_div_nbit (WIDTH=32 and 8)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_div_nbit;

    logic        clk;
    logic        clr;

    logic        s32, sg32;
    logic [31:0] m32, q32;
    logic [63:0] z32;
    logic        b32, d32, dz32, ov32;

    logic        s8, sg8;
    logic [7:0]  m8, q8;
    logic [15:0] z8;
    logic        b8, d8, dz8, ov8;

    int n_checks;
    int n_fail;

    seq_div_nbit #(.WIDTH(32), .SIGNED_EN(1'b1)) u_dut32 (
        .clk(clk), .clr(clr), .start(s32), .is_signed(sg32), .M(m32), .Q(q32),
        .z(z32), .busy(b32), .done(d32), .div_by_zero(dz32), .overflow(ov32)
    );

    seq_div_nbit #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut8 (
        .clk(clk), .clr(clr), .start(s8), .is_signed(sg8), .M(m8), .Q(q8),
        .z(z8), .busy(b8), .done(d8), .div_by_zero(dz8), .overflow(ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after an edge.
    task automatic run_div(input string tag, input bit w8, input bit sgn,
                           input logic [31:0] q, input logic [31:0] m,
                           input logic [63:0] exp_z, input bit exp_dz,
                           input bit exp_ov, input bit poke);
        int   cyc;
        int   busy_cnt;
        int   exp_lat;
        bit   seen;
        logic [63:0] zo;
        exp_lat = exp_dz ? 1 : (w8 ? 9 : 33);
        if (w8) begin
            s8 = 1'b1; sg8 = sgn; q8 = q[7:0]; m8 = m[7:0];
        end else begin
            s32 = 1'b1; sg32 = sgn; q32 = q; m32 = m;
        end
        @(posedge clk); #1;
        s8 = 1'b0; s32 = 1'b0;
        // Operands wander while busy; the result must not follow them.
        q8 = q8 ^ 8'h5A; m8 = m8 + 8'd3;
        q32 = q32 ^ 32'h5A5A_5A5A; m32 = m32 + 32'd3;
        check({tag, "_busy_on_accept"}, {63'd0, (w8 ? b8 : b32)}, 64'd1);
        check({tag, "_flags_clear"}, {62'd0, (w8 ? {dz8, ov8} : {dz32, ov32})}, 64'd0);
        cyc = 0;
        busy_cnt = 1;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            if (poke && cyc == 4) begin
                if (w8) begin s8 = 1'b1; q8 = 8'd77; m8 = 8'd5; end
                else begin s32 = 1'b1; q32 = 32'd77; m32 = 32'd5; end
            end
            @(posedge clk); #1;
            s8 = 1'b0; s32 = 1'b0;
            cyc++;
            if (w8 ? d8 : d32) seen = 1'b1;
            else if (w8 ? b8 : b32) busy_cnt++;
        end
        zo = w8 ? {48'd0, z8} : z32;
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
        check({tag, "_z"}, zo, exp_z);
        check({tag, "_dbz"}, {63'd0, (w8 ? dz8 : dz32)}, {63'd0, exp_dz});
        check({tag, "_ovf"}, {63'd0, (w8 ? ov8 : ov32)}, {63'd0, exp_ov});
        check({tag, "_busy_at_done"}, {63'd0, (w8 ? b8 : b32)}, 64'd0);
        @(posedge clk); #1;
        zo = w8 ? {48'd0, z8} : z32;
        check({tag, "_done_pulse"}, {63'd0, (w8 ? d8 : d32)}, 64'd0);
        check({tag, "_z_hold"}, zo, exp_z);
        check({tag, "_dbz_hold"}, {63'd0, (w8 ? dz8 : dz32)}, {63'd0, exp_dz});
        check({tag, "_idle_after"}, {63'd0, (w8 ? b8 : b32)}, 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clr = 1'b1;
        s32 = 1'b0; sg32 = 1'b0; m32 = '0; q32 = '0;
        s8  = 1'b0; sg8  = 1'b0; m8  = '0; q8  = '0;

        @(posedge clk); #1;
        check("rst_z32", z32, 64'd0);
        check("rst_flags32", {60'd0, b32, d32, dz32, ov32}, 64'd0);
        check("rst_z8", {48'd0, z8}, 64'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;

        run_div("u100_7",  1'b0, 1'b0, 32'd100, 32'd7, {32'd14, 32'd2}, 1'b0, 1'b0, 1'b0);
        run_div("sn100_7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7,
                {32'hFFFF_FFF2, 32'hFFFF_FFFE}, 1'b0, 1'b0, 1'b0);
        run_div("s100_n7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9,
                {32'hFFFF_FFF2, 32'h0000_0002}, 1'b0, 1'b0, 1'b0);
        run_div("sn7_n2",  1'b0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE,
                {32'd3, 32'hFFFF_FFFF}, 1'b0, 1'b0, 1'b0);
        run_div("s0_n3",   1'b0, 1'b1, 32'd0, 32'hFFFF_FFFD, 64'd0, 1'b0, 1'b0, 1'b0);
        run_div("u_msbdiv", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000,
                {32'h0000_0001, 32'h7FFF_FFFF}, 1'b0, 1'b0, 1'b0);
        run_div("u_div1",  1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,
                {32'hFFFF_FFFF, 32'd0}, 1'b0, 1'b0, 1'b0);
        run_div("dbz5",    1'b0, 1'b0, 32'd5, 32'd0,
                {32'hFFFF_FFFF, 32'd5}, 1'b1, 1'b0, 1'b0);
        run_div("dbz_neg", 1'b0, 1'b1, 32'hFFFF_FFFB, 32'd0,
                {32'hFFFF_FFFF, 32'hFFFF_FFFB}, 1'b1, 1'b0, 1'b0);
        run_div("s_ovf",   1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                {32'h8000_0000, 32'd0}, 1'b0, 1'b1, 1'b0);
        run_div("u_noovf", 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
                {32'd0, 32'h8000_0000}, 1'b0, 1'b0, 1'b0);
        run_div("w8_200_9", 1'b1, 1'b0, 32'd200, 32'd9, {48'd0, 8'd22, 8'd2}, 1'b0, 1'b0, 1'b0);
        run_div("w8_sn100_7", 1'b1, 1'b1, 32'h0000_009C, 32'd7,
                {48'd0, 8'hF2, 8'hFE}, 1'b0, 1'b0, 1'b0);

        // Asynchronous clear in the middle of a divide.
        s32 = 1'b1; sg32 = 1'b0; q32 = 32'd100; m32 = 32'd7;
        @(posedge clk); #1;
        s32 = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        clr = 1'b1;
        #1;
        check("clr_z32", z32, 64'd0);
        check("clr_flags32", {60'd0, b32, d32, dz32, ov32}, 64'd0);
        check("clr_z8", {48'd0, z8}, 64'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;

        run_div("after_clr_9_3", 1'b0, 1'b0, 32'd9, 32'd3, {32'd3, 32'd0}, 1'b0, 1'b0, 1'b1);
        run_div("w8_poke", 1'b1, 1'b0, 32'd200, 32'd9, {48'd0, 8'd22, 8'd2}, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
